// File: rtl/icache_if.sv
// Fetcher-side and memory-side signal bundle for icache.
// The hit/miss counters exist only when ICACHE_STATS_EN is defined.
interface icache_if;
  logic        in_fetch_ena;
  logic [31:0] in_fetch_addr;
  logic        in_flush;
  logic        out_busy;
  logic        out_fetch_ok;
  logic [31:0] out_fetch_data;
  logic        in_mem_busy;
  logic        out_mem_ena;
  logic [31:0] out_mem_addr;
  logic        in_mem_ok;
  logic [31:0] in_mem_data;
`ifdef ICACHE_STATS_EN
  logic [31:0] out_hit_cnt;
  logic [31:0] out_miss_cnt;

  modport slave (
    input  in_fetch_ena, in_fetch_addr, in_flush, in_mem_busy, in_mem_ok, in_mem_data,
    output out_busy, out_fetch_ok, out_fetch_data, out_mem_ena, out_mem_addr,
    output out_hit_cnt, out_miss_cnt
  );
  modport master (
    output in_fetch_ena, in_fetch_addr, in_flush, in_mem_busy, in_mem_ok, in_mem_data,
    input  out_busy, out_fetch_ok, out_fetch_data, out_mem_ena, out_mem_addr,
    input  out_hit_cnt, out_miss_cnt
  );
`else
  modport slave (
    input  in_fetch_ena, in_fetch_addr, in_flush, in_mem_busy, in_mem_ok, in_mem_data,
    output out_busy, out_fetch_ok, out_fetch_data, out_mem_ena, out_mem_addr
  );
  modport master (
    output in_fetch_ena, in_fetch_addr, in_flush, in_mem_busy, in_mem_ok, in_mem_data,
    input  out_busy, out_fetch_ok, out_fetch_data, out_mem_ena, out_mem_addr
  );
`endif
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between fetcher and memory.
// Optional hit/miss counters are enabled with ICACHE_STATS_EN.
module icache #(
  parameter int unsigned INDEX_BITS = 6
) (
  input logic     clk,
  input logic     rst,
  icache_if.slave bus
);
  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE = 2'd0, MISS_REQ = 2'd1, MISS_WAIT = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [31:0]           data_q [LINES];
  logic [29:0]           addr_q, addr_d;   // word address of the miss in flight
  logic                  kill_q, kill_d;
  logic                  busy_q, fetch_ok_q, fetch_ok_d, mem_ena_q, mem_ena_d, fill;
  logic [31:0]           fetch_data_q, fetch_data_d, mem_addr_q, mem_addr_d;
  logic [INDEX_BITS-1:0] fetch_idx, fill_idx;
  logic [TAG_W-1:0]      fetch_tag;
  logic                  hit, unused_bits;

  assign fetch_idx   = bus.in_fetch_addr[INDEX_BITS+1:2];
  assign fetch_tag   = bus.in_fetch_addr[31:INDEX_BITS+2];
  assign fill_idx    = addr_q[INDEX_BITS-1:0];
  assign hit         = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign unused_bits = ^bus.in_fetch_addr[1:0];

  // Next-state and registered-output values
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    kill_d       = kill_q;
    fetch_ok_d   = 1'b0;
    fetch_data_d = fetch_data_q;
    mem_ena_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    fill         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.in_flush && bus.in_fetch_ena) begin
          if (hit) begin
            fetch_ok_d   = 1'b1;
            fetch_data_d = data_q[fetch_idx];
          end else begin
            addr_d  = bus.in_fetch_addr[31:2];
            kill_d  = 1'b0;
            state_d = MISS_REQ;
          end
        end
      end
      MISS_REQ: begin
        if (bus.in_flush) begin
          state_d = IDLE;
        end else if (!bus.in_mem_busy) begin
          mem_ena_d  = 1'b1;
          mem_addr_d = {addr_q, 2'b00};
          state_d    = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        if (bus.in_flush) kill_d = 1'b1;
        // Memory cannot abort, so a killed miss still fills the line
        if (bus.in_mem_ok) begin
          fill    = 1'b1;
          state_d = IDLE;
          if (!(kill_q || bus.in_flush)) begin
            fetch_ok_d   = 1'b1;
            fetch_data_d = bus.in_mem_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      addr_q       <= '0;
      kill_q       <= 1'b0;
      busy_q       <= 1'b0;
      fetch_ok_q   <= 1'b0;
      fetch_data_q <= '0;
      mem_ena_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      kill_q       <= kill_d;
      busy_q       <= (state_d != IDLE);
      fetch_ok_q   <= fetch_ok_d;
      fetch_data_q <= fetch_data_d;
      mem_ena_q    <= mem_ena_d;
      mem_addr_q   <= mem_addr_d;
      if (fill) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag/data storage needs no reset; valid bits gate it
  always_ff @(posedge clk) begin
    if (!rst && fill) begin
      tag_q[fill_idx]  <= addr_q[29:INDEX_BITS];
      data_q[fill_idx] <= bus.in_mem_data;
    end
  end

  assign bus.out_busy       = busy_q;
  assign bus.out_fetch_ok   = fetch_ok_q;
  assign bus.out_fetch_data = fetch_data_q;
  assign bus.out_mem_ena    = mem_ena_q;
  assign bus.out_mem_addr   = mem_addr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        accept;

  assign accept = (state_q == IDLE) && !bus.in_flush && bus.in_fetch_ena;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (accept && hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (accept && !hit) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign bus.out_hit_cnt  = hit_cnt_q;
  assign bus.out_miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios, then random fetch/flush/busy traffic
// compared every cycle against a transaction-level cache model and a fixed memory image.
module tb_icache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  icache_if bus();

  icache dut (.clk(clk), .rst(rst), .bus(bus));

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory image: constant contents, one word per word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0000_0100) return 32'h00A0_0093;
    return (w * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  // Memory responder: answers each strobe after a latency, reset by the shared rst
  int          mem_lat_fix = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_raddr = '0;
  initial begin
    bus.in_mem_ok   = 1'b0;
    bus.in_mem_data = '0;
    forever begin
      @(posedge clk); #2;
      bus.in_mem_ok = 1'b0;
      if (rst) begin
        mem_cnt = 0;
      end else begin
        if (mem_cnt > 0) begin
          mem_cnt--;
          if (mem_cnt == 0) begin
            bus.in_mem_ok   = 1'b1;
            bus.in_mem_data = mem_word(mem_raddr);
          end
        end
        if (bus.out_mem_ena) begin
          mem_raddr = bus.out_mem_addr;
          mem_cnt   = (mem_lat_fix > 0) ? mem_lat_fix : int'($urandom_range(1, 4));
        end
      end
    end
  end

  // Reference model: which word each line holds, plus the one outstanding miss
  logic [31:0] m_line [64];
  bit          m_valid [64];
  bit          m_pend = 0, m_sent = 0, m_kill = 0;
  logic [31:0] m_paddr = '0;
  bit          e_ok = 0, e_mena = 0;
  logic [31:0] e_data = '0, e_maddr = '0;
  int          stall = 0;
  int          n_ok = 0, n_mena = 0;
  logic [31:0] last_ok_data = '0, last_mem_addr = '0;
`ifdef ICACHE_STATS_EN
  logic [31:0] m_hits = '0, m_misses = '0;
`endif

  initial begin
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_line[i]  = '0;
    end
    forever begin
      @(negedge clk);
      chk("busy", 32'(bus.out_busy), 32'(m_pend));
      chk("fetch_ok", 32'(bus.out_fetch_ok), 32'(e_ok));
      if (e_ok) chk("fetch_data", bus.out_fetch_data, e_data);
      chk("mem_ena", 32'(bus.out_mem_ena), 32'(e_mena));
      if (e_mena) chk("mem_addr", bus.out_mem_addr, e_maddr);
`ifdef ICACHE_STATS_EN
      chk("hit_cnt", bus.out_hit_cnt, m_hits);
      chk("miss_cnt", bus.out_miss_cnt, m_misses);
`endif
      if (bus.out_fetch_ok) begin n_ok++; last_ok_data = bus.out_fetch_data; end
      if (bus.out_mem_ena) begin n_mena++; last_mem_addr = bus.out_mem_addr; end

      // Advance the model across the coming posedge using the inputs it will sample
      e_ok   = 0;
      e_mena = 0;
      if (rst) begin
        for (int i = 0; i < 64; i++) m_valid[i] = 0;
        m_pend = 0; m_sent = 0; m_kill = 0; stall = 0;
`ifdef ICACHE_STATS_EN
        m_hits = '0; m_misses = '0;
`endif
      end else if (!m_pend) begin
        stall = 0;
        if (!bus.in_flush && bus.in_fetch_ena) begin
          if (m_valid[idx_of(bus.in_fetch_addr)] &&
              m_line[idx_of(bus.in_fetch_addr)] == {bus.in_fetch_addr[31:2], 2'b00}) begin
            e_ok   = 1;
            e_data = mem_word(bus.in_fetch_addr);
`ifdef ICACHE_STATS_EN
            m_hits++;
`endif
          end else begin
            m_pend  = 1; m_sent = 0; m_kill = 0;
            m_paddr = {bus.in_fetch_addr[31:2], 2'b00};
`ifdef ICACHE_STATS_EN
            m_misses++;
`endif
          end
        end
      end else begin
        stall++;
        if (!m_sent) begin
          if (bus.in_flush) m_pend = 0;
          else if (!bus.in_mem_busy) begin
            m_sent  = 1;
            e_mena  = 1;
            e_maddr = m_paddr;
          end
        end else begin
          if (bus.in_flush) m_kill = 1;
          if (bus.in_mem_ok) begin
            m_valid[idx_of(m_paddr)] = 1;
            m_line[idx_of(m_paddr)]  = m_paddr;
            m_pend = 0;
            e_ok   = !m_kill;
            e_data = mem_word(m_paddr);
          end
        end
        if (stall > 300) begin
          errors++;
          $display("FAIL stall: miss to %h outstanding for %0d cycles, want done", m_paddr, stall);
          $display("Result: errors=%0d of %0d checks", errors, checks);
          $fatal(1, "miss never completed");
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.out_busy && n < 100) begin step(); n++; end
    if (n >= 100) chk("idle_timeout", 32'(bus.out_busy), 32'd0);
  endtask

  task automatic wait_issue(input int base);
    int n = 0;
    while (n_mena == base && n < 100) begin step(); n++; end
    if (n >= 100) chk("issue_timeout", 32'(n_mena), 32'(base + 1));
  endtask

  task automatic fetch(input logic [31:0] a);
    wait_idle();
    bus.in_fetch_ena  = 1'b1;
    bus.in_fetch_addr = a;
    step();
    bus.in_fetch_ena = 1'b0;
    wait_idle();
    step(); step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.out_busy), 32'd0);
    chk({tag, "_fetch_ok"}, 32'(bus.out_fetch_ok), 32'd0);
    chk({tag, "_fetch_data"}, bus.out_fetch_data, 32'd0);
    chk({tag, "_mem_ena"}, 32'(bus.out_mem_ena), 32'd0);
    chk({tag, "_mem_addr"}, bus.out_mem_addr, 32'd0);
`ifdef ICACHE_STATS_EN
    chk({tag, "_hit_cnt"}, bus.out_hit_cnt, 32'd0);
    chk({tag, "_miss_cnt"}, bus.out_miss_cnt, 32'd0);
`endif
  endtask

  initial begin
    int b_ena, b_ok;
    bus.in_fetch_ena  = 1'b0;
    bus.in_fetch_addr = '0;
    bus.in_flush      = 1'b0;
    bus.in_mem_busy   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Cold miss
    b_ena = n_mena; b_ok = n_ok;
    fetch(32'h0000_0100);
    chk("cold_mem_ena_count", 32'(n_mena - b_ena), 32'd1);
    chk("cold_mem_addr", last_mem_addr, 32'h0000_0100);
    chk("cold_ok_count", 32'(n_ok - b_ok), 32'd1);
    chk("cold_data", last_ok_data, 32'h00A0_0093);

    // Repeat hits without touching memory
    b_ena = n_mena; b_ok = n_ok;
    fetch(32'h0000_0102);
    chk("hit_mem_ena_count", 32'(n_mena - b_ena), 32'd0);
    chk("hit_ok_count", 32'(n_ok - b_ok), 32'd1);
    chk("hit_data", last_ok_data, 32'h00A0_0093);

    // Conflict on index 0
    b_ena = n_mena;
    fetch(32'h0000_0200);
    chk("conflict_miss", 32'(n_mena - b_ena), 32'd1);
    chk("conflict_addr", last_mem_addr, 32'h0000_0200);
    b_ena = n_mena;
    fetch(32'h0000_0100);
    chk("conflict_refetch_miss", 32'(n_mena - b_ena), 32'd1);
    chk("conflict_refetch_data", last_ok_data, 32'h00A0_0093);

    // Memory busy holds the request back
    b_ena = n_mena;
    bus.in_mem_busy   = 1'b1;
    bus.in_fetch_ena  = 1'b1;
    bus.in_fetch_addr = 32'h0000_0344;
    step();
    bus.in_fetch_ena = 1'b0;
    repeat (5) step();
    chk("busy_held", 32'(n_mena - b_ena), 32'd0);
    bus.in_mem_busy = 1'b0;
    wait_idle(); step(); step();
    chk("busy_released", 32'(n_mena - b_ena), 32'd1);
    chk("busy_addr", last_mem_addr, 32'h0000_0344);

    // Flush while waiting on memory
    mem_lat_fix = 6;
    b_ena = n_mena; b_ok = n_ok;
    bus.in_fetch_ena  = 1'b1;
    bus.in_fetch_addr = 32'h0000_03C8;
    step();
    bus.in_fetch_ena = 1'b0;
    wait_issue(b_ena);
    step();
    bus.in_flush = 1'b1;
    step();
    bus.in_flush = 1'b0;
    chk("flush_still_busy", 32'(bus.out_busy), 32'd1);
    wait_idle(); step(); step();
    chk("flush_no_ok", 32'(n_ok - b_ok), 32'd0);
    b_ena = n_mena;
    fetch(32'h0000_03C8);
    chk("flush_then_hit", 32'(n_mena - b_ena), 32'd0);
    chk("flush_then_hit_ok", 32'(n_ok - b_ok), 32'd1);

    // Reset in the middle of a miss
    b_ena = n_mena; b_ok = n_ok;
    bus.in_fetch_ena  = 1'b1;
    bus.in_fetch_addr = 32'h0000_04C0;
    step();
    bus.in_fetch_ena = 1'b0;
    wait_issue(b_ena);
    rst = 1'b1;
    step();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    step(); step(); step(); step(); step(); step(); step();
    chk("midrst_no_ok", 32'(n_ok - b_ok), 32'd0);
    mem_lat_fix = 1;
    b_ena = n_mena;
    fetch(32'h0000_04C0);
    chk("midrst_refetch_miss", 32'(n_mena - b_ena), 32'd1);
    b_ena = n_mena;
    fetch(32'h0000_0100);
    chk("midrst_cleared_lines", 32'(n_mena - b_ena), 32'd1);

    // Random traffic; the per-cycle model does the checking
    mem_lat_fix = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.in_fetch_ena  = 1'($urandom_range(0, 1));
      bus.in_fetch_addr = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
                          | 32'($urandom_range(0, 3));
      bus.in_flush      = ($urandom_range(0, 19) == 0);
      bus.in_mem_busy   = ($urandom_range(0, 3) == 0);
      rst               = ($urandom_range(0, 399) == 0);
      step();
    end
    bus.in_fetch_ena = 1'b0;
    bus.in_flush     = 1'b0;
    bus.in_mem_busy  = 1'b0;
    rst              = 1'b0;
    wait_idle();
    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
